// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit: divider FSM states and default widths.
package arith_pkg;

  localparam int DIV_N     = 8;
  localparam int DIV_W     = 2 * DIV_N;
  localparam int DIV_CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only if it did not go negative.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   r,
  input  logic         shift_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  // r stays below the divisor between steps, so its top bit is zero and one
  // extra guard bit is enough to read the sign of the trial difference.
  always_comb begin
    shifted = {r, shift_in};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[N+1];
    r_next  = trial[N+1] ? shifted[N:0] : trial[N:0];
  end

endmodule

// File: rtl/seq_divider16by8.sv
// Iterative unsigned restoring divider, 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_divider16by8
  import arith_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [N:0]    r;
  logic [W-1:0]  q;
  logic [N-1:0]  dsr;
  logic [N:0]    r_next;
  logic          q_bit;

  div_step #(.N(N)) u_step (
    .r        (r),
    .shift_in (q[W-1]),
    .divisor  (dsr),
    .r_next   (r_next),
    .q_bit    (q_bit)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dsr         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr      <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              r     <= '0;
              q     <= dividend;
              cnt   <= '0;
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          r   <= r_next;
          q   <= {q[W-2:0], q_bit};
          cnt <= cnt + 1'b1;
          // The result registers load only on the last step, so they stay
          // frozen for the whole DONE phase however long backpressure lasts.
          if (cnt == CW'(W - 1)) begin
            quotient  <= {q[W-2:0], q_bit};
            remainder <= r_next[N-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16by8.sv
// Self-checking bench for seq_divider16by8 against a plain-arithmetic model.
module tb_seq_divider16by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  seq_divider16by8 #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Reference: integer division; a zero divisor yields all-ones and the low dividend byte.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / {8'd0, b};
      r = 8'(a % {8'd0, b});
      z = 1'b0;
    end
  endfunction

  // Presents one operand pair and waits for the result; starts and ends at a negedge.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r, output logic z,
                        output int lat, output bit timeout);
    int n = 0;
    timeout = 1'b0;
    lat     = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout = 1'b1;
      q = 'x; r = 'x; z = 1'bx;
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h z=%b exp rdy=1 vld=0 q=0000 r=00 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [4] = '{16'hFFFF, 16'd1000, 16'd5, 16'h1234};
    logic [7:0]  tb [4] = '{8'hFF, 8'd7, 8'd9, 8'd0};
    logic [15:0] tq [4] = '{16'h0101, 16'h008E, 16'h0000, 16'hFFFF};
    logic [7:0]  tr [4] = '{8'h00, 8'h06, 8'h05, 8'h34};
    int          tl [4] = '{17, 17, 17, 1};
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    bit          to;
    for (int i = 0; i < 4; i++) begin
      do_div(ta[i], tb[i], q, r, z, lat, to);
      checks++;
      if (to || q !== tq[i] || r !== tr[i] || z !== (tb[i] == 8'd0)) begin
        failures++;
        $display("FAIL directed_%0d %h/%h got q=%h r=%h z=%b timeout=%b exp q=%h r=%h z=%b",
                 i, ta[i], tb[i], q, r, z, to, tq[i], tr[i], tb[i] == 8'd0);
      end
      checks++;
      if (lat != tl[i]) begin
        failures++;
        $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, tl[i]);
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL handoff_%0d got rdy=%b vld=%b z=%b exp rdy=1 vld=0 z=0",
                 i, in_ready, out_valid, div_by_zero);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    bit          to;
    do_div(16'hFFFF, 8'd1, q, r, z, lat, to);
    checks++;
    if (to || q !== 16'hFFFF || r !== 8'h00 || z !== 1'b0) begin
      failures++;
      $display("FAIL bp_result got q=%h r=%h z=%b timeout=%b exp q=ffff r=00 z=0", q, r, z, to);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom_range(1, 255));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'hFFFF ||
          remainder !== 8'h00 || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b q=%h r=%h z=%b exp vld=1 rdy=0 q=ffff r=00 z=0",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    bit          to;
    in_valid = 1'b1;
    dividend = 16'hABCD;
    divisor  = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b vld=%b q=%h r=%h z=%b exp rdy=1 vld=0 q=0000 r=00 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    do_div(16'd200, 8'd10, q, r, z, lat, to);
    checks++;
    if (to || q !== 16'd20 || r !== 8'd0 || z !== 1'b0 || lat != 17) begin
      failures++;
      $display("FAIL after_reset got q=%0d r=%0d z=%b lat=%0d timeout=%b exp q=20 r=0 z=0 lat=17",
               q, r, z, lat, to);
    end
    release_result();
  endtask

  task automatic test_random();
    logic [15:0] q, eq;
    logic [7:0]  r, er, b;
    logic        z, ez;
    logic [15:0] a;
    int          lat;
    bit          to;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = (i % 8 == 7) ? 8'd0 : 8'($urandom);
      if (i % 5 == 0) b = 8'($urandom_range(1, 3));
      model(a, b, eq, er, ez);
      do_div(a, b, q, r, z, lat, to);
      checks++;
      if (to || q !== eq || r !== er || z !== ez) begin
        failures++;
        $display("FAIL random_%0d %h/%h got q=%h r=%h z=%b timeout=%b exp q=%h r=%h z=%b",
                 i, a, b, q, r, z, to, eq, er, ez);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    logic [7:0]  a, b;
    int          lat;
    bit          to;
    int          prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      do_div(16'(a) * 16'(b), b, q, r, z, lat, to);
      checks++;
      if (to || q !== {8'd0, a} || r !== 8'd0 || z !== 1'b0) begin
        failures++;
        $display("FAIL roundtrip_%0d a=%h b=%h got q=%h r=%h z=%b timeout=%b exp q=%h r=00 z=0",
                 i, a, b, q, r, z, to, {8'd0, a});
      end
      if (i > 0) begin
        checks++;
        if (cycle - prev != 18) begin
          failures++;
          $display("FAIL throughput_%0d got=%0d exp=18", i, cycle - prev);
        end
      end
      prev = cycle;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
